pipe_stage_elastic: RTL
=======================

# pipe_stage_elastic

Parametrised, elastic successor to the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB latches. One instance sits between two pipeline stages, carrying a control field and a data field under a valid/ready handshake. A two-entry skid buffer keeps `in_ready` registered and gives full throughput. A flush input kills in-flight contents and forces the control field to a NOP bubble.

## Interface
- `DATA_W`, default 96: width of the payload (PC, operands, immediate, register indices packed by the instantiator).
- `CTRL_W`, default 9: width of the control-signal bundle (ALUSrc, RegDst, ALUOp, branch, MemWrite, ...).
- `CTRL_NOP`, default `'0`: control value presented whenever the stage holds no valid entry (bubble).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous kill of all held entries and of the current input beat.
- `in_valid` input 1: upstream beat present.
- `in_ready` output 1: stage can accept; registered, derived from state only.
- `in_ctrl` input CTRL_W: upstream control bundle.
- `in_data` input DATA_W: upstream payload.
- `out_valid` output 1: head entry present.
- `out_ready` input 1: downstream accepts head; low means stall.
- `out_ctrl` output CTRL_W: head control; equals CTRL_NOP whenever `out_valid`=0.
- `out_data` output DATA_W: head payload; holds last value when invalid.
- `occupancy` output 2: entries held (0, 1 or 2).

## Operation
- Fires: `in_fire = in_valid & in_ready & !flush`; `out_fire = out_valid & out_ready`.
- States: EMPTY (0 entries), ONE (main entry valid), TWO (main and skid valid).
- EMPTY: on `in_fire`, go to ONE and load main from the input.
- ONE:
  - `in_fire & out_fire`: stay in ONE; main loads the input.
  - `in_fire & !out_fire`: go to TWO; skid loads the input.
  - `!in_fire & out_fire`: go to EMPTY.
  - Otherwise hold.
- TWO: `in_ready`=0. On `out_fire`, go to ONE and main loads skid. Otherwise hold.
- `flush` has the highest priority. From any state it goes to EMPTY, and main ctrl loads CTRL_NOP.
  - No beat is accepted in the flush cycle, even though `in_ready` may read 1.
  - Upstream must treat `flush` as killing its own beat.
  - A head `out_fire` in the same cycle still counts as delivered downstream.
- Ordering is strictly FIFO. The skid entry never overtakes main.
- `out_ctrl` = main ctrl when `out_valid`, otherwise CTRL_NOP. `out_data` = main data.
- `occupancy` equals the state encoding (0, 1, 2).

## Timing
- Reset (async assert, sync release at the clk edge):
  - State EMPTY.
  - `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - `out_ctrl`=CTRL_NOP, `out_data`=0, skid contents=0.
- Latency: one cycle. A beat accepted at edge N appears on `out_*` after edge N.
- Throughput: one beat per cycle while `out_ready`=1.
- `in_ready` is a flop output, with no combinational path from `out_ready`.
- `out_valid`, `out_ctrl` and `out_data` are driven from flops; `out_ctrl` passes only through the NOP mask.
- After `out_ready` drops, at most one further beat is absorbed (into skid). `in_ready` falls the cycle after skid fills.
- Reset asserted mid-transfer discards both entries immediately, with no edge needed.

## Structure
- Shared package `pipe_pkg`:
  - State enum `pipe_state_t` {EMPTY, ONE, TWO}.
  - Default `PIPE_CTRL_NOP` constant.
  - Occupancy width constant.
- One natural sub-module, `pipe_slot`: a CTRL_W+DATA_W register with load enable and async reset value. It is instantiated twice (main, skid).
- The state machine and the mux selecting input versus skid for main live in the top level.
- Legacy fixed latches are replaced by instances with `out_ready` tied high.

## Test plan
- **Reset and first beat.** Assert `rst` mid-cycle with stale entries. Expect `out_valid`=0, `out_ctrl`=CTRL_NOP and `in_ready`=1 immediately. Then release reset, drive `in_data`=0x1234 and `in_ctrl`=0x1A5 with `in_valid`=1. Expect `out_valid`=1 and `out_data`=0x1234 one edge later.
- **Streaming.** Send 8 beats (values 1..8) with `out_ready`=1. Expect 8 consecutive output cycles in order and `occupancy` steady at 1.
- **Stall.** Drop `out_ready` while streaming 1..8. Expect skid to catch one beat, `occupancy`=2, `in_ready`=0 the next cycle, and no loss or duplication when `out_ready` returns.
- **Flush.** Assert `flush` in TWO state with `in_valid`=1. Expect `out_valid`=0, `out_ctrl`=CTRL_NOP, `occupancy`=0 and the input beat dropped.
- **Flush with head fire.** Assert `flush` together with `out_fire` in ONE state. Expect the head counted as delivered once and the next cycle EMPTY.
- **Random stress.** Random `in_valid`/`out_ready`/rare `flush` over 10k cycles. Check against a scoreboard: in-order delivery, `in_ready` never combinationally dependent on `out_ready`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encoding,
// default bubble control value and occupancy width.
package pipe_pkg;

    localparam int unsigned PIPE_CTRL_W = 9;
    localparam int unsigned PIPE_OCC_W  = 2;

    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_NOP = '0;

    typedef enum logic [PIPE_OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the elastic stage: a load-enabled register holding
// the packed control and data fields, with a configurable reset value.
module pipe_slot #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a two-entry skid buffer; in_ready, out_valid
// and the head entry are all flop outputs, so no ready/valid path is combinational.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W   = 96,
    parameter int unsigned        CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = CTRL_W'(PIPE_CTRL_NOP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    localparam int unsigned SLOT_W = CTRL_W + DATA_W;

    pipe_state_t       state_q, state_d;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              in_fire, out_fire;
    logic              main_ld, skid_ld, main_sel_skid, main_nop;
    logic [SLOT_W-1:0] main_q, main_d, skid_q, in_slot;

    assign in_slot  = {in_ctrl, in_data};
    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d       = state_q;
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = 1'b0;
        main_nop      = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            main_ld  = 1'b1;
            main_nop = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d       = ONE;
                        main_ld       = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // A flushed head keeps its payload (out_data holds) but its control becomes a bubble.
    always_comb begin
        if (main_nop) begin
            main_d = {CTRL_NOP, main_q[DATA_W-1:0]};
        end else if (main_sel_skid) begin
            main_d = skid_q;
        end else begin
            main_d = in_slot;
        end
    end

    // Ready and valid are registered from the next state so both stay flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    pipe_slot #(
        .W       (SLOT_W),
        .RST_VAL ({CTRL_NOP, {DATA_W{1'b0}}})
    ) u_main (
        .clk (clk),
        .rst (rst),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_slot #(
        .W       (SLOT_W),
        .RST_VAL ('0)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .ld  (skid_ld),
        .d   (in_slot),
        .q   (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ctrl  = out_valid_q ? main_q[SLOT_W-1:DATA_W] : CTRL_NOP;
    assign out_data  = main_q[DATA_W-1:0];
    assign occupancy = PIPE_OCC_W'(state_q);

endmodule
